multi_clock_divider: RTL and testbench



---
 rtl/multi_clock_divider_if.sv | 14 +
 rtl/multi_clock_divider.sv | 51 +++++
 tb/tb_multi_clock_divider.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/multi_clock_divider_if.sv
// multi_clock_divider_if: control and divided-clock bundle for multi_clock_divider
interface multi_clock_divider_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
);
  logic [NUM_CH-1:0]       en;
  logic [NUM_CH-1:0]       div_load;
  logic [NUM_CH*CNT_W-1:0] div_value;
  logic                    sync;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       tick;
  modport master (output en, div_load, div_value, sync, input clk_out, tick);
  modport slave  (input en, div_load, div_value, sync, output clk_out, tick);
endinterface

// File: rtl/multi_clock_divider.sv
// multi_clock_divider: per-channel programmable clk_in divider with tick strobe, glitch-free reload and phase sync
module multi_clock_divider #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 64,
  parameter int TEST_MODE   = 0
) (
  input logic clk_in,
  input logic reset_n,
  multi_clock_divider_if.slave bus
);
  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d, div_cur_q, div_cur_d, div_pend_q, div_pend_d, raw, load_val;
    logic pend_valid_q, pend_valid_d, clk_out_q, clk_out_d, tick_q, tick_d;
    logic en, load, wrap, apply;
    assign en   = bus.en[c];
    assign load = bus.div_load[c];
    assign raw  = bus.div_value[c*CNT_W +: CNT_W];
    always_comb begin
      load_val     = (raw < CNT_W'(2)) ? CNT_W'(2) : raw;
      wrap         = (cnt_q == div_cur_q - CNT_W'(1));
      apply        = (load | pend_valid_q) & (bus.sync | ~en | wrap | ((cnt_q == '0) & ~tick_q));
      div_pend_d   = load ? load_val : div_pend_q;
      div_cur_d    = apply ? div_pend_d : div_cur_q;
      pend_valid_d = (load | pend_valid_q) & ~apply;
      cnt_d        = bus.sync ? '0 : ~en ? cnt_q : wrap ? '0 : cnt_q + CNT_W'(1);
      tick_d       = ~bus.sync & en & wrap;
      clk_out_d    = bus.sync ? 1'b0 : en ? (cnt_d >= (div_cur_d >> 1)) : clk_out_q;
    end
    always_ff @(posedge clk_in) begin
      if (!reset_n) begin
        cnt_q        <= '0;
        div_cur_q    <= DEF_DIV;
        div_pend_q   <= DEF_DIV;
        pend_valid_q <= 1'b0;
        clk_out_q    <= 1'b0;
        tick_q       <= 1'b0;
      end else begin
        cnt_q        <= cnt_d;
        div_cur_q    <= div_cur_d;
        div_pend_q   <= div_pend_d;
        pend_valid_q <= pend_valid_d;
        clk_out_q    <= clk_out_d;
        tick_q       <= tick_d;
      end
    end
    assign bus.clk_out[c] = (TEST_MODE != 0) ? clk_in : clk_out_q;
    assign bus.tick[c]    = (TEST_MODE != 0) ? en : tick_q;
  end
endmodule

// File: tb/tb_multi_clock_divider.sv
// tb_multi_clock_divider: scoreboard bench with a period-level reference model plus directed timing checks
module tb_multi_clock_divider;
  localparam int N = 2;
  localparam int W = 16;
  logic clk_in = 1'b0;
  logic reset_n = 1'b0;
  multi_clock_divider_if #(.NUM_CH(N), .CNT_W(W)) bus ();
  multi_clock_divider #(.NUM_CH(N), .CNT_W(W), .DEFAULT_DIV(64), .TEST_MODE(0)) dut (
    .clk_in(clk_in),
    .reset_n(reset_n),
    .bus(bus)
  );
  always #5 clk_in = ~clk_in;
  typedef struct packed {
    logic [N-1:0] co;
    logic [N-1:0] tk;
  } exp_t;
  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int m_phase[N], m_per[N], m_next[N];
  bit m_has_next[N], m_co[N], m_tk[N];
  function automatic int clampv(int v);
    return (v < 2) ? 2 : v;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic cyc(int n);
    repeat (n) @(negedge clk_in);
  endtask
  task automatic load(int ch, int v);
    bus.div_value[ch*W +: W] = W'(v);
    bus.div_load[ch] = 1'b1;
    @(negedge clk_in);
    bus.div_load[ch] = 1'b0;
  endtask
  task automatic wait_tick(int ch, output int n);
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!bus.tick[ch] && n < 2000);
    if (!bus.tick[ch]) begin
      tests++;
      fails++;
      $display("FAIL wait_tick_ch%0d: no tick within %0d cycles", ch, n);
    end
  endtask
  task automatic period(int ch, output int per, output int hi);
    per = 0;
    hi = 0;
    do begin
      @(negedge clk_in);
      per++;
      hi += int'(bus.clk_out[ch]);
    end while (!bus.tick[ch] && per < 2000);
  endtask
  // reference model: phase within the current period, period length, pending period
  initial forever begin
    exp_t e;
    bit run, at_end, fresh;
    @(posedge clk_in);
    for (int i = 0; i < N; i++) begin
      if (!reset_n) begin
        m_phase[i] = 0; m_per[i] = 64; m_next[i] = 64;
        m_has_next[i] = 0; m_co[i] = 0; m_tk[i] = 0;
      end else begin
        run    = bus.en[i];
        at_end = (m_phase[i] == m_per[i] - 1);
        fresh  = (m_phase[i] == 0) && !m_tk[i];
        if (bus.div_load[i]) begin
          m_next[i] = clampv(int'(bus.div_value[i*W +: W]));
          m_has_next[i] = 1;
        end
        if (m_has_next[i] && (bus.sync || !run || at_end || fresh)) begin
          m_per[i] = m_next[i];
          m_has_next[i] = 0;
        end
        if (bus.sync) begin
          m_phase[i] = 0; m_co[i] = 0; m_tk[i] = 0;
        end else if (!run) begin
          m_tk[i] = 0;
        end else begin
          m_tk[i] = at_end;
          m_phase[i] = at_end ? 0 : (m_phase[i] + 1) % 65536;
          m_co[i] = (m_phase[i] >= m_per[i] / 2);
        end
      end
      e.co[i] = m_co[i];
      e.tk[i] = m_tk[i];
    end
    sb.push_back(e);
  end
  initial forever begin
    exp_t e;
    @(negedge clk_in);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      tests += 2;
      if (bus.clk_out !== e.co) begin
        fails++;
        $display("FAIL sb_clk_out: got %b, expected %b (t=%0t)", bus.clk_out, e.co, $time);
      end
      if (bus.tick !== e.tk) begin
        fails++;
        $display("FAIL sb_tick: got %b, expected %b (t=%0t)", bus.tick, e.tk, $time);
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, per, hi, cnt1, al;
    bus.en = '0;
    bus.div_load = '0;
    bus.div_value = '0;
    bus.sync = 1'b0;
    reset_n = 1'b0;
    cyc(2);
    chk("reset_clk_out", 32'(bus.clk_out), 0);
    chk("reset_tick", 32'(bus.tick), 0);
    reset_n = 1'b1;
    bus.en = '1;
    wait_tick(0, n);
    chk("first_tick", n, 64);
    period(0, per, hi);
    chk("default_period", per, 64);
    chk("default_high", hi, 32);
    chk("ch1_default_tick", 32'(bus.tick[1]), 1);
    cyc(10);
    load(0, 4);
    wait_tick(0, n);
    chk("reload_remaining", n + 1, 54);
    period(0, per, hi);
    chk("d4_period", per, 4);
    chk("d4_high", hi, 2);
    load(0, 5);
    wait_tick(0, n);
    period(0, per, hi);
    chk("d5_period", per, 5);
    chk("d5_high", hi, 3);
    load(0, 0);
    wait_tick(0, n);
    period(0, per, hi);
    chk("clamp_period", per, 2);
    chk("clamp_high", hi, 1);
    load(1, 8);
    wait_tick(1, n);
    cyc(5);
    bus.en[1] = 1'b0;
    cyc(10);
    chk("gate_clk_out_held", 32'(bus.clk_out[1]), 1);
    chk("gate_tick_low", 32'(bus.tick[1]), 0);
    bus.en[1] = 1'b1;
    wait_tick(1, n);
    chk("gate_resume", n, 3);
    load(0, 4);
    wait_tick(0, n);
    wait_tick(0, n);
    cyc($urandom_range(0, 7));
    bus.sync = 1'b1;
    cyc(1);
    bus.sync = 1'b0;
    chk("sync_clk_out", 32'(bus.clk_out), 0);
    chk("sync_tick", 32'(bus.tick), 0);
    cnt1 = 0;
    al = 0;
    repeat (32) begin
      @(negedge clk_in);
      if (bus.tick[1]) begin
        cnt1++;
        if (bus.tick[0]) al++;
      end
    end
    chk("sync_ch1_ticks", cnt1, 4);
    chk("sync_aligned", al, 4);
    wait_tick(0, n);
    cyc(3);
    bus.sync = 1'b1;
    cyc(1);
    bus.sync = 1'b0;
    chk("sync_wins_tick", 32'(bus.tick[0]), 0);
    chk("sync_wins_clk_out", 32'(bus.clk_out[0]), 0);
    cyc(5);
    load(0, 10);
    reset_n = 1'b0;
    cyc(1);
    chk("midreset_clk_out", 32'(bus.clk_out), 0);
    chk("midreset_tick", 32'(bus.tick), 0);
    reset_n = 1'b1;
    wait_tick(0, n);
    chk("midreset_pending_lost", n, 64);
    repeat (1500) begin
      for (int i = 0; i < N; i++) begin
        bus.en[i] = ($urandom_range(0, 9) != 0);
        bus.div_load[i] = ($urandom_range(0, 15) == 0);
        bus.div_value[i*W +: W] = W'($urandom_range(0, 12));
      end
      bus.sync = ($urandom_range(0, 63) == 0);
      reset_n = ($urandom_range(0, 499) != 0);
      cyc(1);
    end
    bus.div_load = '0;
    bus.sync = 1'b0;
    reset_n = 1'b1;
    cyc(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
